controle_jogo_param: RTL and testbench

CONTROLE_JOGO_PARAM -- requirements
Module: controle_jogo_param

---
 rtl/jogo_pkg.sv | 32 +++
 rtl/contador_vidas.sv | 25 ++
 rtl/controle_jogo_param.sv | 209 ++++++++++++++++++++
 tb/tb_controle_jogo_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared state codes and widths for the game controller.
// CONTROLE_JOGO_VIDAS_EN (when defined) enables the multi-life logic in the top.
package jogo_pkg;

    localparam int W_DB_ESTADO = 5;

    // Debug code shown on db_estado when the state register holds an unused value
    localparam logic [W_DB_ESTADO-1:0] ESTADO_ILEGAL = 5'h1F;

    typedef enum logic [W_DB_ESTADO-1:0] {
        INICIAL       = 5'h00,
        INICIALIZA    = 5'h01,
        PREPARA       = 5'h02,
        MOSTRA        = 5'h03,
        INICIA_RODADA = 5'h04,
        ESPERA        = 5'h06,
        REGISTRA      = 5'h07,
        COMPARA       = 5'h08,
        PROXIMA       = 5'h09,
        FIM_ACERTO    = 5'h0A,
        PROC_ADIC     = 5'h0B,
        ESPERA_ADIC   = 5'h0C,
        REG_ADIC      = 5'h0D,
        FIM_ERRO      = 5'h0E,
        GRAVA         = 5'h0F,
        AUMENTA       = 5'h10,
        VERIFICA      = 5'h11,
        FIM_TIMEOUT   = 5'h12,
        PERDE_VIDA    = 5'h13
    } estado_t;

endpackage

// File: rtl/contador_vidas.sv
// Lives register: loads MAX_VIDAS, counts down one per lost life, never wraps.
module contador_vidas #(
    parameter int MAX_VIDAS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic       decrementa,
    output logic [3:0] vidas,
    output logic       zero
);

    // Load has priority; decrement stops at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            vidas <= 4'd0;
        else if (carrega)
            vidas <= 4'(MAX_VIDAS);
        else if (decrementa && (vidas != 4'd0))
            vidas <= vidas - 4'd1;
    end

    assign zero = (vidas == 4'd0);

endmodule

// File: rtl/controle_jogo_param.sv
// Moore controller for the memory game: sequences display, play, compare,
// round growth, lives and score. Macro CONTROLE_JOGO_VIDAS_EN enables
// multiple lives; without it any lost life ends the game.
module controle_jogo_param
    import jogo_pkg::*;
#(
    parameter int MAX_VIDAS = 3,
    parameter int W_PONTOS  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   jogada,
    input  logic                   igual,
    input  logic                   fimRodada,
    input  logic                   fimTotal,
    input  logic                   fimTimeout,
    input  logic                   fimExibicao,
    input  logic                   cfgTimeout,
    output logic                   contaC,
    output logic                   zeraC,
    output logic                   registraR,
    output logic                   zeraR,
    output logic                   zeraCL,
    output logic                   contaCL,
    output logic                   escreve,
    output logic                   mostraLeds,
    output logic                   contaExibicao,
    output logic                   zeraExibicao,
    output logic                   contaTimeout,
    output logic                   zeraTimeout,
    output logic                   acertou,
    output logic                   errou,
    output logic                   errou_timeout,
    output logic                   pronto,
    output logic                   perdeu_vida,
    output logic [3:0]             vidas,
    output logic [W_PONTOS-1:0]    pontos,
    output logic [W_DB_ESTADO-1:0] db_estado
);

    estado_t estadoAtual, proximoEstado;
    logic    porTimeout;   // remembers whether PERDE_VIDA was reached by timeout

`ifdef CONTROLE_JOGO_VIDAS_EN
    logic [3:0] vidasCnt;
    logic       vidasZero;

    contador_vidas #(.MAX_VIDAS(MAX_VIDAS)) uVidas (
        .clock      (clock),
        .reset      (reset),
        .carrega    (estadoAtual == INICIALIZA),
        .decrementa (estadoAtual == PERDE_VIDA),
        .vidas      (vidasCnt),
        .zero       (vidasZero)
    );

    assign vidas = vidasCnt;
`else
    // Single-life build: MAX_VIDAS is at least 1, so this always reads 1
    assign vidas = 4'(MAX_VIDAS >= 1);
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            estadoAtual <= INICIAL;
        else
            estadoAtual <= proximoEstado;
    end

    // Cause of the pending life loss, captured on entry to PERDE_VIDA
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            porTimeout <= 1'b0;
        else if (proximoEstado == PERDE_VIDA)
            porTimeout <= (estadoAtual != COMPARA);
    end

    // Score: cleared per game, +1 on each entry to VERIFICA, saturating
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pontos <= '0;
        else if (estadoAtual == INICIALIZA)
            pontos <= '0;
        else if (estadoAtual == COMPARA && igual && fimRodada && (pontos != {W_PONTOS{1'b1}}))
            pontos <= pontos + W_PONTOS'(1);
    end

    // Next state and Moore output decode
    always_comb begin
        proximoEstado = estadoAtual;
        contaC        = 1'b0;
        zeraC         = 1'b0;
        registraR     = 1'b0;
        zeraR         = 1'b0;
        zeraCL        = 1'b0;
        contaCL       = 1'b0;
        escreve       = 1'b0;
        mostraLeds    = 1'b0;
        contaExibicao = 1'b0;
        zeraExibicao  = 1'b0;
        contaTimeout  = 1'b0;
        zeraTimeout   = 1'b0;
        acertou       = 1'b0;
        errou         = 1'b0;
        errou_timeout = 1'b0;
        pronto        = 1'b0;
        perdeu_vida   = 1'b0;
        db_estado     = estadoAtual;

        case (estadoAtual)
            INICIAL: begin
                zeraC = 1'b1; zeraR = 1'b1; zeraExibicao = 1'b1;
                if (iniciar) proximoEstado = INICIALIZA;
            end
            INICIALIZA: begin
                zeraC = 1'b1; zeraR = 1'b1; zeraCL = 1'b1;
                zeraExibicao = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = PREPARA;
            end
            PREPARA: begin
                zeraC = 1'b1; escreve = 1'b1; zeraExibicao = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = MOSTRA;
            end
            MOSTRA: begin
                contaExibicao = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                if (fimExibicao) proximoEstado = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                zeraC = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = ESPERA;
            end
            ESPERA: begin
                contaTimeout = 1'b1; mostraLeds = 1'b1;
                if (jogada)                       proximoEstado = REGISTRA;
                else if (cfgTimeout && fimTimeout) proximoEstado = PERDE_VIDA;
            end
            REGISTRA: begin
                registraR = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = COMPARA;
            end
            COMPARA: begin
                mostraLeds = 1'b1; zeraTimeout = 1'b1;
                if (!igual)         proximoEstado = PERDE_VIDA;
                else if (fimRodada) proximoEstado = VERIFICA;
                else                proximoEstado = PROXIMA;
            end
            PROXIMA: begin
                contaC = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = ESPERA;
            end
            VERIFICA: begin
                mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = fimTotal ? FIM_ACERTO : PROC_ADIC;
            end
            PROC_ADIC: begin
                contaC = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = ESPERA_ADIC;
            end
            ESPERA_ADIC: begin
                contaTimeout = 1'b1; mostraLeds = 1'b1;
                if (jogada)                       proximoEstado = REG_ADIC;
                else if (cfgTimeout && fimTimeout) proximoEstado = PERDE_VIDA;
            end
            REG_ADIC: begin
                registraR = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = GRAVA;
            end
            GRAVA: begin
                escreve = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = AUMENTA;
            end
            AUMENTA: begin
                contaCL = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
                proximoEstado = INICIA_RODADA;
            end
            PERDE_VIDA: begin
                perdeu_vida = 1'b1; mostraLeds = 1'b1; zeraTimeout = 1'b1;
`ifdef CONTROLE_JOGO_VIDAS_EN
                // Lives left after this one: replay the same round
                if (!vidasZero && (vidasCnt != 4'd1))
                    proximoEstado = INICIA_RODADA;
                else
                    proximoEstado = porTimeout ? FIM_TIMEOUT : FIM_ERRO;
`else
                proximoEstado = porTimeout ? FIM_TIMEOUT : FIM_ERRO;
`endif
            end
            FIM_ACERTO: begin
                acertou = 1'b1; pronto = 1'b1;
                if (iniciar) proximoEstado = INICIALIZA;
            end
            FIM_ERRO: begin
                errou = 1'b1; pronto = 1'b1;
                if (iniciar) proximoEstado = INICIALIZA;
            end
            FIM_TIMEOUT: begin
                errou = 1'b1; errou_timeout = 1'b1; pronto = 1'b1;
                if (iniciar) proximoEstado = INICIALIZA;
            end
            default: begin
                proximoEstado = INICIAL;
                db_estado     = ESTADO_ILEGAL;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_jogo_param.sv
// Self-checking bench for controle_jogo_param: directed scenarios plus
// random games, checked against a game-level model (lives, score, outcome).
module tb_controle_jogo_param;

    localparam int MAXV = 3;
    localparam int WP   = 2;
    localparam int MAXP = (1 << WP) - 1;
`ifdef CONTROLE_JOGO_VIDAS_EN
    localparam bit LIVES_ON = 1'b1;
`else
    localparam bit LIVES_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic iniciar = 0, jogada = 0, igual = 1, fimRodada = 0, fimTotal = 0;
    logic fimTimeout = 0, fimExibicao = 0, cfgTimeout = 0;
    logic contaC, zeraC, registraR, zeraR, zeraCL, contaCL, escreve, mostraLeds;
    logic contaExibicao, zeraExibicao, contaTimeout, zeraTimeout;
    logic acertou, errou, errou_timeout, pronto, perdeu_vida;
    logic [3:0]    vidas;
    logic [WP-1:0] pontos;
    logic [4:0]    db_estado;

    controle_jogo_param #(.MAX_VIDAS(MAXV), .W_PONTOS(WP)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .fimRodada(fimRodada), .fimTotal(fimTotal),
        .fimTimeout(fimTimeout), .fimExibicao(fimExibicao), .cfgTimeout(cfgTimeout),
        .contaC(contaC), .zeraC(zeraC), .registraR(registraR), .zeraR(zeraR),
        .zeraCL(zeraCL), .contaCL(contaCL), .escreve(escreve), .mostraLeds(mostraLeds),
        .contaExibicao(contaExibicao), .zeraExibicao(zeraExibicao),
        .contaTimeout(contaTimeout), .zeraTimeout(zeraTimeout),
        .acertou(acertou), .errou(errou), .errou_timeout(errou_timeout),
        .pronto(pronto), .perdeu_vida(perdeu_vida),
        .vidas(vidas), .pontos(pontos), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Game-level model
    int livesExp;
    int roundsDone;
    bit over;

    function automatic int scoreExp();
        return (roundsDone > MAXP) ? MAXP : roundsDone;
    endfunction

    function automatic int resetLives();
        return LIVES_ON ? 0 : 1;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkSt(input string tag, input logic [7:0] code);
        chk(tag, 8'(db_estado), code);
    endtask

    task automatic chkModel(input string tag);
        chk({tag, "_vidas"},  8'(vidas),  8'(livesExp));
        chk({tag, "_pontos"}, 8'(pontos), 8'(scoreExp()));
    endtask

    // From INICIAL or a FIM state, bring a fresh game to its first ESPERA
    task automatic startGame();
        livesExp   = LIVES_ON ? MAXV : 1;
        roundsDone = 0;
        over       = 0;
        iniciar = 1; step(); iniciar = 0;
        chkSt("st_inicializa", 8'h01);
        chk("zeraCL_latency", 8'(zeraCL), 8'd1);
        step(); chkSt("st_prepara", 8'h02);
        step(); chkSt("st_mostra", 8'h03);
        chk("mostraLeds_mostra", 8'(mostraLeds), 8'd1);
        fimExibicao = 1; step(); fimExibicao = 0;
        chkSt("st_inicia_rodada", 8'h04);
        step(); chkSt("st_espera", 8'h06);
        chkModel("start");
    endtask

    // Lost-life aftermath, starting while in PERDE_VIDA
    task automatic lose(input bit tmo);
        if (LIVES_ON && livesExp > 1) begin
            livesExp--;
            step(); chkSt("st_replay", 8'h04);
            chk("perdeu_vida_pulse", 8'(perdeu_vida), 8'd0);
            step(); chkSt("st_espera_replay", 8'h06);
            chkModel("replay");
        end else begin
            if (LIVES_ON) livesExp = 0;
            step();
            chkSt("st_fim", tmo ? 8'h12 : 8'h0E);
            chk("errou", 8'(errou), 8'd1);
            chk("errou_timeout", 8'(errou_timeout), 8'(tmo));
            chk("pronto", 8'(pronto), 8'd1);
            chkModel("fim");
            over = 1;
        end
    endtask

    // 0 ok mid-round, 1 ok with simultaneous timeout, 2 round end + continue,
    // 3 round end + game end, 4 mismatch, 5 timeout
    task automatic move(input int kind);
        case (kind)
            0, 1, 2, 3, 4: begin
                igual     = (kind != 4);
                fimRodada = (kind == 2 || kind == 3);
                fimTotal  = (kind == 3);
                if (kind == 1) begin cfgTimeout = 1; fimTimeout = 1; end
                jogada = 1; step(); jogada = 0; cfgTimeout = 0; fimTimeout = 0;
                chkSt("st_registra", 8'h07);
                step(); chkSt("st_compara", 8'h08);
                step();
                if (kind == 4) begin
                    chkSt("st_perde_vida", 8'h13);
                    chk("perdeu_vida", 8'(perdeu_vida), 8'd1);
                    igual = 1;
                    lose(1'b0);
                end else if (kind <= 1) begin
                    chkSt("st_proxima", 8'h09);
                    step(); chkSt("st_espera_next", 8'h06);
                    chkModel("mid");
                end else begin
                    roundsDone++;
                    chkSt("st_verifica", 8'h11);
                    chk("pontos_verifica", 8'(pontos), 8'(scoreExp()));
                    step();
                    if (kind == 3) begin
                        chkSt("st_fim_acerto", 8'h0A);
                        chk("acertou", 8'(acertou), 8'd1);
                        chk("pronto_acerto", 8'(pronto), 8'd1);
                        over = 1;
                    end else begin
                        chkSt("st_proc_adic", 8'h0B);
                        step(); chkSt("st_espera_adic", 8'h0C);
                        jogada = 1; step(); jogada = 0;
                        chkSt("st_reg_adic", 8'h0D);
                        step(); chkSt("st_grava", 8'h0F);
                        step(); chkSt("st_aumenta", 8'h10);
                        chk("contaCL", 8'(contaCL), 8'd1);
                        step(); chkSt("st_inicia_rodada2", 8'h04);
                        step(); chkSt("st_espera_round", 8'h06);
                        chkModel("round");
                    end
                end
                fimRodada = 0; fimTotal = 0;
            end
            default: begin
                cfgTimeout = 1; fimTimeout = 1; step(); cfgTimeout = 0; fimTimeout = 0;
                chkSt("st_perde_vida_tmo", 8'h13);
                chk("perdeu_vida_tmo", 8'(perdeu_vida), 8'd1);
                lose(1'b1);
            end
        endcase
    endtask

    initial begin
        // Reset state
        #12;
        chkSt("rst_estado", 8'h00);
        chk("rst_vidas", 8'(vidas), 8'(resetLives()));
        chk("rst_pontos", 8'(pontos), 8'd0);
        chk("rst_status", {3'b0, acertou, errou, errou_timeout, pronto, perdeu_vida}, 8'd0);
        chk("rst_zera", {6'b0, zeraC, zeraR}, 8'd3);
        reset = 0;
        step(); chkSt("idle_hold", 8'h00);

        // Consecutive mismatches until the game is lost
        startGame();
        while (!over) move(4);
        step(); chkSt("fim_erro_hold", 8'h0E);

        // Timeout gated by cfgTimeout, then timeouts at the last life
        startGame();
        fimTimeout = 1; step(); fimTimeout = 0;
        chkSt("no_cfg_timeout", 8'h06);
        chk("contaTimeout", 8'(contaTimeout), 8'd1);
        while (livesExp > 1) move(4);
        move(5);

        // Play beats timeout; score saturates over five rounds
        startGame();
        move(1);
        move(0);
        for (int r = 0; r < 4; r++) move(2);
        move(3);

        // Reset in ESPERA_ADIC discards progress
        startGame();
        igual = 1; fimRodada = 1; jogada = 1; step(); jogada = 0;
        step(); step(); step(); step(); fimRodada = 0;
        chkSt("pre_rst_espera_adic", 8'h0C);
        #2 reset = 1; #1;
        chkSt("async_rst_estado", 8'h00);
        chk("async_rst_vidas", 8'(vidas), 8'(resetLives()));
        chk("async_rst_pontos", 8'(pontos), 8'd0);
        #2 reset = 0;
        step(); chkSt("post_rst_idle", 8'h00);

        // Random games against the model
        for (int g = 0; g < 8; g++) begin
            startGame();
            for (int n = 0; n < 30 && !over; n++) move(int'($urandom_range(0, 5)));
            if (!over) begin
                reset = 1; #1;
                chkSt("rand_rst", 8'h00);
                #2 reset = 0;
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
